data_memory_hs: RTL
===================

// Module: data_memory_hs
// PURPOSE
//  Parametrised single-port data memory behind a valid/ready request/response handshake.
//  It has configurable read latency, out-of-range detection and read-before-write write acknowledges.
//  It replaces the combinational-read 8-bit data memory in the SIC-4 datapath.
//  The load/store unit issues one transaction at a time and stalls on req_ready/rsp_valid.
// PARAMETERS
//  DATA_WIDTH  8               word width, bits
//  ADDR_WIDTH  8               address width, bits
//  DEPTH       256             words implemented; 1..2**ADDR_WIDTH
//  LATENCY     2               cycles from request accept to rsp_valid; >=1
//  INIT_FILE   "data_mem.dat"  hex image loaded with $readmemh at time 0; "" = no load
// PORTS
//  clk        in   1           clock, all state on posedge
//  reset      in   1           synchronous, active-high
//  req_valid  in   1           request present
//  req_ready  out  1           block can accept a request
//  req_we     in   1           1 = write, 0 = read
//  req_addr   in   ADDR_WIDTH  word address
//  req_wdata  in   DATA_WIDTH  write data
//  rsp_valid  out  1           response present; held until taken
//  rsp_ready  in   1           consumer takes the response
//  rsp_rdata  out  DATA_WIDTH  read data; for writes, the pre-write contents
//  rsp_err    out  1           request address >= DEPTH
// BEHAVIOUR
//  - States: IDLE, WAIT, RESP (plus CLEAR when DMEM_CLEAR_EN is defined). req_ready = (state==IDLE).
//  - Accept: the request is accepted on a posedge with req_valid && req_ready. On that edge:
//    - rsp_rdata <= mem[addr], read before any write.
//    - If req_we, then mem[addr] <= req_wdata.
//    - rsp_err <= (addr >= DEPTH).
//    - The latency counter loads LATENCY-1.
//    - Next state is RESP if LATENCY==1, else WAIT.
//  - WAIT: the counter decrements each cycle. At 1 the next state is RESP.
//    rsp_valid rises exactly LATENCY cycles after the accept edge.
//  - RESP: rsp_valid=1. rsp_rdata and rsp_err are held stable until rsp_valid && rsp_ready,
//    then the block returns to IDLE. A new request cannot be accepted in the same cycle,
//    so the minimum period is LATENCY+1 cycles.
//  - Out of range (addr >= DEPTH): rsp_rdata=0, the write is dropped and memory is unchanged,
//    rsp_err=1. No address wrap.
//  - Request inputs are ignored when req_ready=0. Only one transaction is outstanding.
//  - Reset, synchronous: state IDLE, rsp_valid=0, rsp_rdata=0, rsp_err=0, counter=0.
//    Memory is not cleared unless DMEM_CLEAR_EN is defined.
//    Reset mid-transaction drops the response; a write committed on its accept edge stays written.
//    Reset wins over any simultaneous accept, so that write is not committed.
//  - Memory is an inferred reg array. There is no combinational path from req_* to rsp_*.
// CONFIGURATION
//  DMEM_CLEAR_EN
//  - Defined: reset enters CLEAR instead of IDLE. An index counter writes 0 to addresses
//    0..DEPTH-1, one per cycle, with req_ready=0, then goes to IDLE after DEPTH cycles.
//    Reset during CLEAR restarts the sweep at 0. INIT_FILE contents are overwritten by the first reset.
//  - Undefined: no CLEAR state. Contents survive reset. req_ready=1 on the first cycle after reset.
// TESTING
//  - Read, LATENCY=2: mem[0x10]=0xA5 via INIT_FILE; read 0x10 accepted at edge N
//    -> rsp_valid at edge N+2, rsp_rdata=0xA5, rsp_err=0.
//  - Write then read: write 0x3C to 0x20 (old 0x00) -> rsp_rdata=0x00;
//    then read 0x20 -> 0x3C.
//  - Backpressure: hold rsp_ready=0 for 5 cycles in RESP
//    -> rsp_valid/rsp_rdata stable, req_ready=0, new req_valid ignored; release -> IDLE next cycle.
//  - Out of range, DEPTH=200: write 0x77 to 0xC8 -> rsp_err=1, rsp_rdata=0;
//    read 0xC8 -> 0x00, err=1; read 0xC7 unaffected.
//  - Reset mid-op: assert reset in WAIT after a write of 0x55 to 0x01 -> rsp_valid never rises;
//    after reset, read 0x01 returns 0x55 (0x00 with DMEM_CLEAR_EN).
//  - DMEM_CLEAR_EN, DEPTH=16: reset -> req_ready=0 for 16 cycles; afterwards every address reads 0x00.

Source files
------------

// File: rtl/data_memory_hs.sv
// data_memory_hs: single-port data memory behind a valid/ready request/response handshake.
// Latency: rsp_valid rises LATENCY cycles after accept; one transaction outstanding, period >= LATENCY+1.
// Backpressure: response held in RESP until rsp_ready; req_ready low whenever not IDLE.
// Optional DMEM_CLEAR_EN: reset sweeps zeros through every word before requests are accepted.
module data_memory_hs #(
  parameter int    DATA_WIDTH = 8,
  parameter int    ADDR_WIDTH = 8,
  parameter int    DEPTH      = 256,
  parameter int    LATENCY    = 2,
  parameter string INIT_FILE  = "data_mem.dat"
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err
);

  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0]         CNT_LOAD = CW'(LATENCY - 1);
  localparam logic [ADDR_WIDTH:0]   DEPTH_W  = (ADDR_WIDTH + 1)'(DEPTH);

`ifdef DMEM_CLEAR_EN
  typedef enum logic [1:0] {IDLE, WAIT, RESP, CLEAR} state_t;
  localparam state_t RESET_STATE = CLEAR;
  localparam logic [IW-1:0] CLR_LAST = IW'(DEPTH - 1);
  logic [IW-1:0] clr_idx;
`else
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  localparam state_t RESET_STATE = IDLE;
`endif

  state_t                  state, state_nxt;
  logic [CW-1:0]           cnt;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];
  logic [DATA_WIDTH-1:0]   rdata_q;
  logic                    err_q;
  logic                    accept;
  logic                    in_range;
  logic [IW-1:0]           mem_idx;

  assign accept    = req_valid && (state == IDLE);
  assign in_range  = ({1'b0, req_addr} < DEPTH_W);
  assign mem_idx   = IW'(req_addr);
  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

  // State register; reset wins over everything, including a same-edge accept.
  always_ff @(posedge clk) begin
    if (reset) state <= RESET_STATE;
    else       state <= state_nxt;
  end

  // Next-state logic: accept -> (WAIT) -> RESP -> IDLE once the response is taken.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (req_valid) begin
          if (LATENCY == 1) state_nxt = RESP;
          else              state_nxt = WAIT;
        end
      end
      WAIT:    if (cnt == CW'(1)) state_nxt = RESP;
      RESP:    if (rsp_ready)     state_nxt = IDLE;
`ifdef DMEM_CLEAR_EN
      CLEAR:   if (clr_idx == CLR_LAST) state_nxt = IDLE;
`endif
      default: state_nxt = IDLE;
    endcase
  end

  // Response capture on accept (read-before-write) and latency countdown while waiting.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt     <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else if (accept) begin
      cnt     <= CNT_LOAD;
      rdata_q <= in_range ? mem[mem_idx] : '0;
      err_q   <= !in_range;
    end else if (state == WAIT) begin
      cnt     <= cnt - 1'b1;
    end
  end

  // Memory writes: in-range accepted writes, or the zero sweep after reset.
  always_ff @(posedge clk) begin
    if (!reset && accept && req_we && in_range) begin
      mem[mem_idx] <= req_wdata;
    end
`ifdef DMEM_CLEAR_EN
    else if (!reset && state == CLEAR) begin
      mem[clr_idx] <= '0;
    end
`endif
  end

`ifdef DMEM_CLEAR_EN
  // Sweep index; every reset restarts the sweep at word 0.
  always_ff @(posedge clk) begin
    if (reset)               clr_idx <= '0;
    else if (state == CLEAR) clr_idx <= clr_idx + 1'b1;
  end
`endif

endmodule
